// File: rtl/parity_framer.sv
// ---------------------------------------------------------------------------
// parity_framer
//
// Serial parity framer. Bits arrive one per accepted clock edge; a running
// parity is kept over the current frame of FRAME_LEN bits. When the last bit
// of a frame is accepted, the frame parity is latched on p and p_vld pulses
// for one cycle. Frames may run back-to-back with no idle cycles, and gaps
// (x_vld low) may occur anywhere inside a frame.
//
// Optional feature (macro PARITY_CHECK_EN):
//   Each frame carries one extra received parity bit after the FRAME_LEN data
//   bits. That bit is compared with the computed parity; err reports the
//   result and p_vld pulses when the comparison completes instead of after
//   the last data bit.
//
// Parameters
//   FRAME_LEN  data bits per frame, 2..255
//   ODD        0 = even parity, 1 = odd parity
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort of the current frame (wins over x_vld)
//   x_vld      x is accepted on a rising edge when x_vld=1 and clr=0
//   x          serial data bit
//   z          running parity of the current frame, XOR ODD (registered)
//   bit_cnt    bits accepted so far in the current frame (registered)
//   p_vld      one-cycle pulse marking frame completion (registered)
//   p          frame parity, held until the next completion (registered)
//   err        received parity bit disagreed with p (PARITY_CHECK_EN only)
//   dbg_state  current FSM state: 0 = DATA, 1 = CHK (always 0 without the
//              check feature)
//
// Handshake: a bit is transferred on every rising edge where x_vld=1 and
// clr=0. There is no back-pressure; the framer accepts a bit every cycle.
// ---------------------------------------------------------------------------
module parity_framer #(
  parameter int FRAME_LEN = 8,
  parameter bit ODD       = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       x_vld,
  input  logic       x,
  output logic       z,
  output logic [7:0] bit_cnt,
  output logic       p_vld,
  output logic       p,
`ifdef PARITY_CHECK_EN
  output logic       err,
`endif
  output logic       dbg_state
);

  // Index of the final data bit of a frame, in bit_cnt units.
  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic {
    S_DATA = 1'b0,
    S_CHK  = 1'b1
  } state_t;
`else
  typedef enum logic {
    S_DATA = 1'b0
  } state_t;
`endif

  state_t     r_state;
  logic       r_acc;
  logic [7:0] r_cnt;
  logic       r_p;
  logic       r_p_vld;
`ifdef PARITY_CHECK_EN
  logic       r_err;
`endif

  logic w_accept;
  logic w_last;
  logic w_frame_p;

  assign w_accept  = x_vld && !clr;
  assign w_last    = (r_cnt == LAST_IDX);
  // Parity of the whole frame including the bit being accepted now.
  assign w_frame_p = r_acc ^ x ^ ODD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_DATA;
      r_acc   <= 1'b0;
      r_cnt   <= 8'd0;
      r_p     <= 1'b0;
      r_p_vld <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      // p_vld is a pulse; it is only raised by the completion branches below.
      r_p_vld <= 1'b0;
      if (clr) begin
        // Abort: drop the partial frame. p and err keep their last values.
        r_state <= S_DATA;
        r_acc   <= 1'b0;
        r_cnt   <= 8'd0;
      end else if (w_accept) begin
`ifdef PARITY_CHECK_EN
        if (r_state == S_CHK) begin
          // Received parity bit: compare with the computed frame parity.
          // acc and bit_cnt are already zero from the last data bit.
          r_err   <= (x != r_p);
          r_p_vld <= 1'b1;
          r_state <= S_DATA;
        end else
`endif
        if (w_last) begin
          r_p   <= w_frame_p;
          r_acc <= 1'b0;
          r_cnt <= 8'd0;
`ifdef PARITY_CHECK_EN
          // Completion is reported after the received parity bit.
          r_state <= S_CHK;
`else
          r_p_vld <= 1'b1;
          r_state <= S_DATA;
`endif
        end else begin
          r_acc <= r_acc ^ x;
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  // z is derived from the registered accumulator only, so it is a registered
  // value and takes ODD immediately on reset.
  assign z         = r_acc ^ ODD;
  assign bit_cnt   = r_cnt;
  assign p_vld     = r_p_vld;
  assign p         = r_p;
  assign dbg_state = (r_state != S_DATA);
`ifdef PARITY_CHECK_EN
  assign err       = r_err;
`endif

endmodule

// File: tb/tb_parity_framer.sv
// ---------------------------------------------------------------------------
// tb_parity_framer
//
// Directed bench for parity_framer with FRAME_LEN=4. Two instances share the
// same stimulus: u_even (ODD=0) and u_odd (ODD=1), so every frame exercises
// both parity senses. Expected values are hand-computed per vector. The
// optional check feature is covered when PARITY_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_parity_framer;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       x_vld;
  logic       x;

  logic       e_z, e_p_vld, e_p, e_dbg;
  logic [7:0] e_cnt;
  logic       o_z, o_p_vld, o_p, o_dbg;
  logic [7:0] o_cnt;
`ifdef PARITY_CHECK_EN
  logic       e_err, o_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  parity_framer #(.FRAME_LEN(4), .ODD(1'b0)) u_even (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .x_vld     (x_vld),
    .x         (x),
    .z         (e_z),
    .bit_cnt   (e_cnt),
    .p_vld     (e_p_vld),
    .p         (e_p),
`ifdef PARITY_CHECK_EN
    .err       (e_err),
`endif
    .dbg_state (e_dbg)
  );

  parity_framer #(.FRAME_LEN(4), .ODD(1'b1)) u_odd (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .x_vld     (x_vld),
    .x         (x),
    .z         (o_z),
    .bit_cnt   (o_cnt),
    .p_vld     (o_p_vld),
    .p         (o_p),
`ifdef PARITY_CHECK_EN
    .err       (o_err),
`endif
    .dbg_state (o_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  // Present one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic v, input logic b, input logic c);
    x_vld = v;
    x     = b;
    clr   = c;
    @(posedge clk);
    #1;
    x_vld = 1'b0;
    x     = 1'b0;
    clr   = 1'b0;
  endtask

  // A non-final data bit: bit count, running parity, no completion pulse.
  task automatic dbit(input logic b, input logic [7:0] ecnt, input logic ez);
    drive(1'b1, b, 1'b0);
    check("bit_cnt", e_cnt, ecnt);
    check("z_even", e_z, ez);
    check("z_odd", o_z, !ez);
    check("p_vld_mid", e_p_vld, 8'd0);
  endtask

  // Final data bit of a frame (plus the received parity bit in check mode).
  task automatic fend(input logic b, input logic ep);
    drive(1'b1, b, 1'b0);
    check("cnt_end", e_cnt, 8'd0);
    check("z_end_even", e_z, 8'd0);
    check("z_end_odd", o_z, 8'd1);
    check("p_even", e_p, ep);
    check("p_odd", o_p, !ep);
`ifdef PARITY_CHECK_EN
    check("p_vld_wait", e_p_vld, 8'd0);
    check("state_chk", e_dbg, 8'd1);
    drive(1'b1, ep, 1'b0);
    check("p_vld_chk", e_p_vld, 8'd1);
    check("err_ok", e_err, 8'd0);
    check("state_data", e_dbg, 8'd0);
    check("cnt_chk", e_cnt, 8'd0);
    check("p_chk", e_p, ep);
`else
    check("p_vld_end", e_p_vld, 8'd1);
    check("p_vld_odd", o_p_vld, 8'd1);
    check("state_data", e_dbg, 8'd0);
`endif
  endtask

  // Full 4-bit frame, bits[3] sent first.
  task automatic frame4(input logic [3:0] bits, input logic ep);
    logic rz;
    rz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rz = rz ^ bits[3-i];
      dbit(bits[3-i], 8'(i + 1), rz);
    end
    fend(bits[0], ep);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    x_vld = 1'b0;
    x     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_cnt", e_cnt, 8'd0);
    check("rst_z_even", e_z, 8'd0);
    check("rst_z_odd", o_z, 8'd1);
    check("rst_p", e_p, 8'd0);
    check("rst_p_vld", e_p_vld, 8'd0);
    check("rst_state", e_dbg, 8'd0);

    // Frame 1,1,0,1: z 1,0,0 then p=1, single pulse
    dbit(1'b1, 8'd1, 1'b1);
    dbit(1'b1, 8'd2, 1'b0);
    dbit(1'b0, 8'd3, 1'b0);
    fend(1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("p_vld_one_cycle", e_p_vld, 8'd0);
    check("p_held", e_p, 8'd1);

    // Same bits with a 3-cycle gap between bits 2 and 3 (odd instance p=0)
    dbit(1'b1, 8'd1, 1'b1);
    dbit(1'b1, 8'd2, 1'b0);
    repeat (3) begin
      drive(1'b0, 1'b1, 1'b0);
      check("gap_cnt", o_cnt, 8'd2);
      check("gap_z_odd", o_z, 8'd1);
      check("gap_p_vld", o_p_vld, 8'd0);
    end
    dbit(1'b0, 8'd3, 1'b0);
    fend(1'b1, 1'b1);

    // Back-to-back frames: p=1 then p=0, no idle cycle
    frame4(4'b1000, 1'b1);
    frame4(4'b1111, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("b2b_p_vld_off", e_p_vld, 8'd0);

    // clr during bit 3 with x_vld=1: bit dropped, p held
    dbit(1'b1, 8'd1, 1'b1);
    dbit(1'b1, 8'd2, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check("clr_cnt", e_cnt, 8'd0);
    check("clr_z_even", e_z, 8'd0);
    check("clr_z_odd", o_z, 8'd1);
    check("clr_p_vld", e_p_vld, 8'd0);
    check("clr_p_held_even", e_p, 8'd0);
    check("clr_p_held_odd", o_p, 8'd1);
    frame4(4'b0001, 1'b1);

`ifdef PARITY_CHECK_EN
    // Wrong received parity: 1,0,1,1 has even parity 1, send 0
    dbit(1'b1, 8'd1, 1'b1);
    dbit(1'b0, 8'd2, 1'b1);
    dbit(1'b1, 8'd3, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check("chk_no_pulse", e_p_vld, 8'd0);
    check("chk_p", e_p, 8'd1);
    drive(1'b1, 1'b0, 1'b0);
    check("err_set", e_err, 8'd1);
    check("err_p_vld", e_p_vld, 8'd1);
    drive(1'b0, 1'b0, 1'b1);
    check("err_hold_clr", e_err, 8'd1);
    check("err_clr_p_vld", e_p_vld, 8'd0);
    // Correct parity again clears err
    frame4(4'b1011, 1'b1);
    dbit(1'b1, 8'd1, 1'b1);
    dbit(1'b0, 8'd2, 1'b1);
    dbit(1'b1, 8'd3, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check("err_set2", e_err, 8'd1);
`endif

    // Async reset between edges after 2 bits
    dbit(1'b1, 8'd1, 1'b1);
    dbit(1'b1, 8'd2, 1'b0);
    #2 rst_n = 1'b0;
    #2;
    check("arst_cnt", e_cnt, 8'd0);
    check("arst_z_even", e_z, 8'd0);
    check("arst_z_odd", o_z, 8'd1);
    check("arst_p", e_p, 8'd0);
    check("arst_p_vld", e_p_vld, 8'd0);
`ifdef PARITY_CHECK_EN
    check("arst_err", e_err, 8'd0);
`endif
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame4(4'b1110, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
